// File: rtl/square_arbiter_if.sv
// Request, response and squarer-side signal bundle for square_arbiter.
// master = arbiter side, slave = requesters/consumer/squarer side.
interface square_arbiter_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_data;
  logic              rsp_err;
  logic              rsp_ready;
  logic              sq_start;
  logic [N-1:0]      sq_data;
  logic [2*N-1:0]    sq_result;
  logic              sq_done;
  logic              busy;

  modport master (
    input  req_valid, req_data, rsp_ready, sq_result, sq_done,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, sq_start, sq_data, busy
  );

  modport slave (
    output req_valid, req_data, rsp_ready, sq_result, sq_done,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, sq_start, sq_data, busy
  );
endinterface

// File: rtl/square_arbiter.sv
// Round-robin arbiter sharing one squarer between NREQ requesters with a tagged response channel.
// Optional WAIT-state timeout enabled by defining SQ_ARB_TIMEOUT_EN.
module square_arbiter #(
  parameter int unsigned N       = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  square_arbiter_if.master  bus
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned RW  = 2 * N;

  if (NREQ < 2 || TIMEOUT == 0) begin : g_bad_cfg
    $error("square_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state, w_state_n;
  logic [IDW-1:0]  r_ptr, w_ptr_n;
  logic [N-1:0]    r_operand, w_operand_n;
  logic [IDW-1:0]  r_rsp_id, w_rsp_id_n;
  logic [RW-1:0]   r_rsp_data, w_rsp_data_n;
  logic            r_rsp_valid;
  logic            r_sq_start;
  logic            r_busy;

  logic            w_found;
  logic [IDW-1:0]  w_gid;
  logic [IDW-1:0]  w_idx;
  logic [NREQ-1:0] w_req_ready;

`ifdef SQ_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic            r_rsp_err, w_rsp_err_n;
`endif

  // Priority scan starting at r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % int'(NREQ));
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gid   = w_idx;
      end
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    w_state_n    = r_state;
    w_ptr_n      = r_ptr;
    w_operand_n  = r_operand;
    w_rsp_id_n   = r_rsp_id;
    w_rsp_data_n = r_rsp_data;
    w_req_ready  = '0;
`ifdef SQ_ARB_TIMEOUT_EN
    w_cnt_n      = r_cnt;
    w_rsp_err_n  = r_rsp_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_req_ready[w_gid] = 1'b1;
          w_operand_n        = bus.req_data[int'(w_gid)*int'(N) +: N];
          w_rsp_id_n         = w_gid;
          w_state_n          = S_ISSUE;
`ifdef SQ_ARB_TIMEOUT_EN
          w_cnt_n            = '0;
`endif
        end
      end
      S_ISSUE: begin
        w_state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.sq_done) begin
          w_rsp_data_n = bus.sq_result;
          w_state_n    = S_RESP;
`ifdef SQ_ARB_TIMEOUT_EN
          w_rsp_err_n  = 1'b0;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          // Limit reached without a result: report an error response.
          w_rsp_data_n = '0;
          w_rsp_err_n  = 1'b1;
          w_state_n    = S_RESP;
        end else begin
          w_cnt_n      = CW'(r_cnt + 1'b1);
`endif
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_ptr_n   = (r_rsp_id == IDW'(NREQ - 1)) ? '0 : IDW'(r_rsp_id + 1'b1);
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; strobes derive from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_operand   <= '0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_sq_start  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SQ_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_ptr       <= w_ptr_n;
      r_operand   <= w_operand_n;
      r_rsp_id    <= w_rsp_id_n;
      r_rsp_data  <= w_rsp_data_n;
      r_rsp_valid <= (w_state_n == S_RESP);
      r_sq_start  <= (w_state_n == S_ISSUE);
      r_busy      <= (w_state_n != S_IDLE);
`ifdef SQ_ARB_TIMEOUT_EN
      r_cnt       <= w_cnt_n;
      r_rsp_err   <= w_rsp_err_n;
`endif
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.sq_start  = r_sq_start;
  assign bus.sq_data   = r_operand;
  assign bus.busy      = r_busy;
`ifdef SQ_ARB_TIMEOUT_EN
  assign bus.rsp_err   = r_rsp_err;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_square_arbiter.sv
// Directed bench for square_arbiter with a one-cycle squarer model.
// Timeout checks follow SQ_ARB_TIMEOUT_EN when it is defined.
module tb_square_arbiter;
  localparam int unsigned N    = 8;
  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  square_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  square_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic        sq_en;
  logic        f_done;
  logic        m_done;
  logic [15:0] m_result;

  // One-cycle squarer; sq_en=0 models a squarer that never answers.
  always @(posedge clk) begin
    if (rst) m_done <= 1'b0;
    else     m_done <= sq_en & bus.sq_start;
    if (bus.sq_start) m_result <= 16'(bus.sq_data) * 16'(bus.sq_data);
  end
  assign bus.sq_done   = m_done | f_done;
  assign bus.sq_result = m_result;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] d);
    bus.req_valid[id]          = 1'b1;
    bus.req_data[id*N +: N]    = d;
  endtask

  // Called at a negedge in IDLE with requests driven; returns at the next idle negedge.
  task automatic run_op(input int id, input logic [15:0] exp);
    #1;
    check_eq("grant", bus.req_ready, 32'(1) << id);
    check_eq("idle_rsp_valid", bus.rsp_valid, 0);
    check_eq("idle_busy", bus.busy, 0);
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    #1;
    check_eq("sq_start", bus.sq_start, 1);
    check_eq("sq_data", bus.sq_data, 32'(bus.req_data[id*N +: N]));
    check_eq("busy", bus.busy, 1);
    check_eq("ready_zero_issue", bus.req_ready, 0);
    @(negedge clk);
    #1;
    check_eq("early_rsp", bus.rsp_valid, 0);
    check_eq("start_pulse", bus.sq_start, 0);
    @(negedge clk);
    #1;
    check_eq("rsp_valid", bus.rsp_valid, 1);
    check_eq("rsp_id", bus.rsp_id, id);
    check_eq("rsp_data", bus.rsp_data, exp);
    check_eq("rsp_err", bus.rsp_err, 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    sq_en         = 1'b1;
    f_done        = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_id", bus.rsp_id, 0);
    check_eq("rst_rsp_data", bus.rsp_data, 0);
    check_eq("rst_rsp_err", bus.rsp_err, 0);
    check_eq("rst_sq_start", bus.sq_start, 0);
    check_eq("rst_sq_data", bus.sq_data, 0);
    check_eq("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single request from id 2.
    set_req(2, 8'hFF);
    run_op(2, 16'hFE01);

    // All four after reset: ids served in order, 4 cycles apart.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 8'd3);
    set_req(1, 8'd5);
    set_req(2, 8'd7);
    set_req(3, 8'd9);
    run_op(0, 16'd9);
    run_op(1, 16'd25);
    run_op(2, 16'd49);
    run_op(3, 16'd81);

    // Fairness: pointer wrapped to 0 after id 3.
    set_req(0, 8'd2);
    set_req(3, 8'd4);
    run_op(0, 16'd4);
    run_op(3, 16'd16);

    // Backpressure on the response channel.
    bus.rsp_ready = 1'b0;
    set_req(1, 8'h10);
    #1;
    check_eq("bp_grant", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) set_req(2, 8'd6);
      #1;
      check_eq("bp_rsp_valid", bus.rsp_valid, 1);
      check_eq("bp_rsp_id", bus.rsp_id, 1);
      check_eq("bp_rsp_data", bus.rsp_data, 16'h0100);
      check_eq("bp_req_ready", bus.req_ready, 0);
      check_eq("bp_sq_start", bus.sq_start, 0);
      check_eq("bp_busy", bus.busy, 1);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    check_eq("bp_release_valid", bus.rsp_valid, 1);
    @(negedge clk);
    run_op(2, 16'd36);

    // Squarer stops answering.
    sq_en = 1'b0;
    set_req(2, 8'h55);
    #1;
    check_eq("stuck_grant", bus.req_ready, 4'b0100);
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
`ifdef SQ_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1;
      check_eq("to_wait_valid", bus.rsp_valid, 0);
      check_eq("to_wait_busy", bus.busy, 1);
    end
    @(negedge clk);
    #1;
    check_eq("to_rsp_valid", bus.rsp_valid, 1);
    check_eq("to_rsp_err", bus.rsp_err, 1);
    check_eq("to_rsp_data", bus.rsp_data, 0);
    check_eq("to_rsp_id", bus.rsp_id, 2);
    @(negedge clk);
    #1;
    check_eq("to_done_valid", bus.rsp_valid, 0);
    check_eq("to_done_busy", bus.busy, 0);
    set_req(0, 8'h21);
    #1;
    check_eq("to_next_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check_eq("hang_rsp_valid", bus.rsp_valid, 0);
      check_eq("hang_busy", bus.busy, 1);
    end
`endif

    // Reset during WAIT followed by a stray sq_done.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    f_done = 1'b1;
    #1;
    check_eq("mid_rsp_valid", bus.rsp_valid, 0);
    check_eq("mid_rsp_id", bus.rsp_id, 0);
    check_eq("mid_rsp_data", bus.rsp_data, 0);
    check_eq("mid_rsp_err", bus.rsp_err, 0);
    check_eq("mid_sq_start", bus.sq_start, 0);
    check_eq("mid_sq_data", bus.sq_data, 0);
    check_eq("mid_busy", bus.busy, 0);
    check_eq("mid_req_ready", bus.req_ready, 0);
    @(negedge clk);
    f_done = 1'b0;
    sq_en  = 1'b1;
    #1;
    check_eq("stray_rsp_valid", bus.rsp_valid, 0);
    check_eq("stray_busy", bus.busy, 0);
    check_eq("stray_sq_start", bus.sq_start, 0);
    set_req(1, 8'd12);
    set_req(3, 8'd13);
    run_op(1, 16'd144);
    run_op(3, 16'd169);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
